// File: rtl/cpu_pkg.sv
// Shared widths, FSM state type and helpers for the writeback stage and register file.
package cpu_pkg;

  localparam int DATA_W   = 16;
  localparam int REG_W    = 4;
  localparam int NUM_REGS = 2 ** REG_W;
  localparam int CNT_W    = 16;

  localparam logic [REG_W-1:0] REG_ZERO = 4'h0;

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } wb_state_t;

  // Saturating increment used by both perf counters.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/wb_regfile_if.sv
// MEM/WB pipeline inputs, decode read ports and writeback status outputs.
interface wb_regfile_if;
  import cpu_pkg::*;

  logic              wb_hlt;
  logic              wb_from_mem;
  logic              wb_WriteReg;
  logic [REG_W-1:0]  wb_DstReg;
  logic [DATA_W-1:0] wb_MemData;
  logic [DATA_W-1:0] wb_DstData;
  logic [REG_W-1:0]  SrcReg1;
  logic [REG_W-1:0]  SrcReg2;
  logic [DATA_W-1:0] SrcData1;
  logic [DATA_W-1:0] SrcData2;
  logic              wb_wen;
  logic [DATA_W-1:0] wb_data;
  logic              halted;
  logic [CNT_W-1:0]  cyc_count;
  logic [CNT_W-1:0]  wr_count;

  modport master (
    output wb_hlt, wb_from_mem, wb_WriteReg, wb_DstReg, wb_MemData, wb_DstData,
           SrcReg1, SrcReg2,
    input  SrcData1, SrcData2, wb_wen, wb_data, halted, cyc_count, wr_count
  );

  modport slave (
    input  wb_hlt, wb_from_mem, wb_WriteReg, wb_DstReg, wb_MemData, wb_DstData,
           SrcReg1, SrcReg2,
    output SrcData1, SrcData2, wb_wen, wb_data, halted, cyc_count, wr_count
  );

endinterface

// File: rtl/rf_bank.sv
// Register storage: one write port, two combinational read ports with R0 forcing
// and same-cycle write bypass.
module rf_bank
  import cpu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [REG_W-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [REG_W-1:0]  raddr1,
  input  logic [REG_W-1:0]  raddr2,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2
);

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] regs_d [NUM_REGS];

  // NOTE: every always_comb output gets a full default first so no latch is inferred.
  always_comb begin
    regs_d = regs_q;
    if (we && waddr != REG_ZERO) regs_d[waddr] = wdata;
  end

  // NOTE: the array is reset because the architecture defines all registers as zero
  // after reset; this keeps it in flops rather than a RAM macro, which is fine at 16x16.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  function automatic logic [DATA_W-1:0] read_port(input logic [REG_W-1:0] idx);
    if (idx == REG_ZERO)           return '0;
    else if (we && idx == waddr)   return wdata;
    else                           return regs_q[idx];
  endfunction

  assign rdata1 = read_port(raddr1);
  assign rdata2 = read_port(raddr2);

endmodule

// File: rtl/wb_regfile.sv
// Writeback stage: data select, write qualification, halt sequencer and perf counters
// around the architectural register file.
module wb_regfile
  import cpu_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  wb_regfile_if.slave  bus
);

  wb_state_t        state_q, state_d;
  logic             halted_q, halted_d;
  logic [CNT_W-1:0] cyc_count_q, cyc_count_d;
  logic [CNT_W-1:0] wr_count_q, wr_count_d;

  logic              wen;
  logic [DATA_W-1:0] wdata;

  assign wdata = bus.wb_from_mem ? bus.wb_MemData : bus.wb_DstData;
  // HLT retires without writing, and nothing commits once halted.
  assign wen   = (state_q == RUN) && bus.wb_WriteReg && !bus.wb_hlt &&
                 (bus.wb_DstReg != REG_ZERO);

  always_comb begin
    state_d     = state_q;
    halted_d    = halted_q;
    cyc_count_d = cyc_count_q;
    wr_count_d  = wr_count_q;
    if (state_q == RUN) begin
      cyc_count_d = sat_inc(cyc_count_q);
      if (bus.wb_hlt) begin
        state_d  = HALTED;
        halted_d = 1'b1;
      end
    end
    if (wen) wr_count_d = sat_inc(wr_count_q);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RUN;
      halted_q    <= 1'b0;
      cyc_count_q <= '0;
      wr_count_q  <= '0;
    end else begin
      state_q     <= state_d;
      halted_q    <= halted_d;
      cyc_count_q <= cyc_count_d;
      wr_count_q  <= wr_count_d;
    end
  end

  rf_bank u_rf_bank (
    .clk    (clk),
    .rst    (rst),
    .we     (wen),
    .waddr  (bus.wb_DstReg),
    .wdata  (wdata),
    .raddr1 (bus.SrcReg1),
    .raddr2 (bus.SrcReg2),
    .rdata1 (bus.SrcData1),
    .rdata2 (bus.SrcData2)
  );

  assign bus.wb_wen    = wen;
  assign bus.wb_data   = wdata;
  assign bus.halted    = halted_q;
  assign bus.cyc_count = cyc_count_q;
  assign bus.wr_count  = wr_count_q;

endmodule
